addx_fu_arbiter_ctrl: RTL and testbench
=======================================

Name: addx_fu_arbiter_ctrl

Overview:
Sequencer and arbiter for the shared multi-cycle ADDX/accelerator datapath. Two requesters share one datapath instance: req0 is the issue-stage ADDX path, req1 is the accelerator port. The block arbitrates round-robin, latches operands, starts the datapath and waits for completion with a timeout. It returns the result tagged with the scoreboard trans_id, and handles pipeline flush.

Parameters:
XLEN, 32, operand/result width
TRANS_ID_BITS, 3, scoreboard tag width (8 scoreboard entries)
TIMEOUT, 64, max cycles from dp_start_o to dp_done_i before abort (>=2)

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
flush_i  in  1  pipeline flush, kills in-flight op
req0_valid_i / req1_valid_i  in  1  request valid
req0_ready_o / req1_ready_o  out  1  request accepted (grant)
req0_op_a_i, req0_op_b_i / req1_op_a_i, req1_op_b_i  in  XLEN  operands
req0_trans_id_i / req1_trans_id_i  in  TRANS_ID_BITS  tag
dp_start_o  out  1  one-cycle datapath start pulse
dp_abort_o  out  1  one-cycle datapath abort pulse
dp_op_a_o, dp_op_b_o  out  XLEN  latched operands, stable from start until next accept
dp_done_i  in  1  datapath completion pulse
dp_result_i  in  XLEN  result, valid with dp_done_i
res_valid_o  out  1  result valid
res_ready_i  in  1  result consumed
res_result_o  out  XLEN  result
res_trans_id_o  out  TRANS_ID_BITS  tag of the op
res_src_o  out  1  0=req0, 1=req1
res_timeout_o  out  1  op aborted by timeout, result forced 0
busy_o  out  1  state != IDLE

Behaviour:
- Reset (rst_i=1 at a clock edge): state IDLE, all outputs 0, rr pointer prefers req0, timeout counter 0. Reset mid-op drops the op. No abort pulse is emitted on reset.
- States: IDLE, RUN, RESP, DRAIN.
- IDLE: ready is combinational. reqX_ready_o=1 only if state==IDLE, !flush_i, reqX_valid_i, and X wins arbitration. At most one ready is high per cycle.
- Arbitration: only one valid wins. If both are valid, the preferred one wins. After a grant, the preference moves to the other requester.
- Accept (valid&ready at edge N): latch operands, tag and source. Go to RUN. dp_start_o=1 in cycle N+1 only.
- RUN: timeout counter is cleared at start and increments each cycle after the start cycle. dp_done_i is honoured only from the cycle after dp_start_o; done in the start cycle is ignored.
- RUN, done: register dp_result_i. Go to RESP; res_valid_o=1 from the next cycle.
- RUN, timeout: TIMEOUT cycles after the start cycle with no done, pulse dp_abort_o for 1 cycle. Go to RESP with res_result_o=0 and res_timeout_o=1.
- RUN, done and timeout in the same cycle: done wins and no abort is issued.
- RESP: res_* outputs are held stable while res_valid_o && !res_ready_i. Handshake at an edge goes to IDLE. A new accept is possible the cycle after. Minimum op period is 4 cycles with 1-cycle datapath latency.
- flush_i has priority over all other events:
  - IDLE: nothing is accepted that cycle.
  - RUN: go to DRAIN; no abort pulse; the result will be discarded.
  - RESP: drop the result; res_valid_o=0 next cycle; go to IDLE.
- DRAIN: wait for dp_done_i and discard it, then go to IDLE. The timeout counter continues; on expiry pulse dp_abort_o and go to IDLE. No res_valid_o in DRAIN. busy_o=1.
- flush_i in DRAIN has no extra effect.
- dp_done_i outside RUN/DRAIN is ignored.
- res_timeout_o is cleared whenever res_valid_o falls.

Test Plan:
- Single op: req0 valid, op_a=0x10, op_b=0x20, tag=5, dp_done_i with 0x30 two cycles after start -> dp_start_o one cycle after accept; res_valid_o, result 0x30, tag 5, src 0; IDLE after res_ready_i.
- Contention: req0 and req1 valid continuously, both answered immediately -> grants alternate 0,1,0,1; exactly one ready per cycle; src alternates.
- Backpressure: res_ready_i low 5 cycles -> res_* stable for 5 cycles, no new grant, busy_o=1.
- Timeout: TIMEOUT=64, no done -> dp_abort_o pulse 64 cycles after the start cycle; res_valid_o with result 0, res_timeout_o=1; done arriving in that same cycle instead -> normal result, no abort.
- Flush in RUN then done 3 cycles later -> DRAIN, no res_valid_o, IDLE after done, next request accepted. Flush in RESP -> result dropped.
- rst_i asserted in RUN -> all outputs 0 next cycle, state IDLE, req0 preferred, late dp_done_i ignored.

Source files
------------

// File: rtl/addx_fu_arbiter_ctrl.sv
// Round-robin arbiter and sequencer for the shared multi-cycle ADDX/accelerator datapath.
// Grants one of two requesters, drives the datapath start/abort, and returns a tagged result.
module addx_fu_arbiter_ctrl #(
    parameter int XLEN          = 32,
    parameter int TRANS_ID_BITS = 3,
    parameter int TIMEOUT       = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     req0_valid_i,
    output logic                     req0_ready_o,
    input  logic [XLEN-1:0]          req0_op_a_i,
    input  logic [XLEN-1:0]          req0_op_b_i,
    input  logic [TRANS_ID_BITS-1:0] req0_trans_id_i,
    input  logic                     req1_valid_i,
    output logic                     req1_ready_o,
    input  logic [XLEN-1:0]          req1_op_a_i,
    input  logic [XLEN-1:0]          req1_op_b_i,
    input  logic [TRANS_ID_BITS-1:0] req1_trans_id_i,
    output logic                     dp_start_o,
    output logic                     dp_abort_o,
    output logic [XLEN-1:0]          dp_op_a_o,
    output logic [XLEN-1:0]          dp_op_b_o,
    input  logic                     dp_done_i,
    input  logic [XLEN-1:0]          dp_result_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [XLEN-1:0]          res_result_o,
    output logic [TRANS_ID_BITS-1:0] res_trans_id_o,
    output logic                     res_src_o,
    output logic                     res_timeout_o,
    output logic                     busy_o
);

    // Counter must reach TIMEOUT+1: a flush landing on the expiry cycle defers the abort into DRAIN.
    localparam int CNT_W = $clog2(TIMEOUT + 2);

    typedef enum logic [1:0] {IDLE, RUN, RESP, DRAIN} state_t;

    state_t                   state;
    logic                     pref;
    logic [CNT_W-1:0]         cnt;
    logic [TRANS_ID_BITS-1:0] op_tag;
    logic                     op_src;

    logic grant0, grant1, accept, done_ok, tmo_hit;

    always_comb begin
        grant0  = req0_valid_i && (!req1_valid_i || !pref);
        grant1  = req1_valid_i && (!req0_valid_i || pref);
        done_ok = dp_done_i && !dp_start_o;
        tmo_hit = (cnt >= CNT_W'(TIMEOUT));
    end

    assign req0_ready_o = (state == IDLE) && !flush_i && grant0;
    assign req1_ready_o = (state == IDLE) && !flush_i && grant1;
    assign accept       = req0_ready_o || req1_ready_o;
    assign busy_o       = (state != IDLE);

    // Abort is decided in the expiry cycle itself so a coincident done can still win.
    assign dp_abort_o = ((state == RUN) && !flush_i && !done_ok && tmo_hit) ||
                        ((state == DRAIN) && !dp_done_i && tmo_hit);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state          <= IDLE;
            pref           <= 1'b0;
            cnt            <= '0;
            op_tag         <= '0;
            op_src         <= 1'b0;
            dp_start_o     <= 1'b0;
            dp_op_a_o      <= '0;
            dp_op_b_o      <= '0;
            res_valid_o    <= 1'b0;
            res_result_o   <= '0;
            res_trans_id_o <= '0;
            res_src_o      <= 1'b0;
            res_timeout_o  <= 1'b0;
        end else begin
            dp_start_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        dp_op_a_o  <= req1_ready_o ? req1_op_a_i : req0_op_a_i;
                        dp_op_b_o  <= req1_ready_o ? req1_op_b_i : req0_op_b_i;
                        op_tag     <= req1_ready_o ? req1_trans_id_i : req0_trans_id_i;
                        op_src     <= req1_ready_o;
                        pref       <= req0_ready_o;
                        cnt        <= '0;
                        dp_start_o <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (flush_i) begin
                        state <= DRAIN;
                    end else if (done_ok || tmo_hit) begin
                        res_valid_o    <= 1'b1;
                        res_result_o   <= done_ok ? dp_result_i : '0;
                        res_timeout_o  <= !done_ok;
                        res_trans_id_o <= op_tag;
                        res_src_o      <= op_src;
                        state          <= RESP;
                    end
                end
                RESP: begin
                    if (flush_i || res_ready_i) begin
                        res_valid_o   <= 1'b0;
                        res_timeout_o <= 1'b0;
                        state         <= IDLE;
                    end
                end
                DRAIN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (dp_done_i || tmo_hit) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_addx_fu_arbiter_ctrl.sv
// Directed bench for addx_fu_arbiter_ctrl: a cycle table for basic/contention traffic,
// then hand-written sequences for backpressure, timeout, flush and reset.
module tb_addx_fu_arbiter_ctrl;

    localparam int  XLEN = 32;
    localparam int  TIDB = 3;
    localparam int  TMO  = 64;
    localparam logic H = 1'b1;
    localparam logic L = 1'b0;

    logic            clk = 1'b0;
    logic            rst_i = 1'b1;
    logic            flush_i = 1'b0;
    logic            req0_valid_i = 1'b0, req1_valid_i = 1'b0;
    logic            req0_ready_o, req1_ready_o;
    logic [XLEN-1:0] req0_op_a_i = 32'h10, req0_op_b_i = 32'h20;
    logic [XLEN-1:0] req1_op_a_i = 32'hA,  req1_op_b_i = 32'hB;
    logic [TIDB-1:0] req0_trans_id_i = 3'd5, req1_trans_id_i = 3'd2;
    logic            dp_start_o, dp_abort_o;
    logic [XLEN-1:0] dp_op_a_o, dp_op_b_o;
    logic            dp_done_i = 1'b0;
    logic [XLEN-1:0] dp_result_i = '0;
    logic            res_valid_o;
    logic            res_ready_i = 1'b0;
    logic [XLEN-1:0] res_result_o;
    logic [TIDB-1:0] res_trans_id_o;
    logic            res_src_o, res_timeout_o, busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    addx_fu_arbiter_ctrl #(.XLEN(XLEN), .TRANS_ID_BITS(TIDB), .TIMEOUT(TMO)) dut (
        .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i),
        .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
        .req0_op_a_i(req0_op_a_i), .req0_op_b_i(req0_op_b_i), .req0_trans_id_i(req0_trans_id_i),
        .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
        .req1_op_a_i(req1_op_a_i), .req1_op_b_i(req1_op_b_i), .req1_trans_id_i(req1_trans_id_i),
        .dp_start_o(dp_start_o), .dp_abort_o(dp_abort_o),
        .dp_op_a_o(dp_op_a_o), .dp_op_b_o(dp_op_b_o),
        .dp_done_i(dp_done_i), .dp_result_i(dp_result_i),
        .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
        .res_result_o(res_result_o), .res_trans_id_o(res_trans_id_o),
        .res_src_o(res_src_o), .res_timeout_o(res_timeout_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic v0, v1, fl, dn;
        logic [31:0] res;
        logic rr;
        logic e_r0, e_r1, e_st, e_rv;
        logic [31:0] e_res;
        logic e_src, e_busy;
    } vec_t;

    vec_t tbl[18];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Present a lone request, confirm its grant, and return positioned in the start cycle.
    task automatic start_op(input logic sel);
        req0_valid_i = !sel;
        req1_valid_i = sel;
        #1;
        chk1("grant_ready", sel ? req1_ready_o : req0_ready_o, H);
        tick();
        req0_valid_i = 1'b0;
        req1_valid_i = 1'b0;
    endtask

    initial begin
        int abort_seen;
        // Fields: v0 v1 flush done result res_ready | ready0 ready1 start res_valid result src busy
        tbl[0]  = '{H, L, L, L, 32'h00, L,  H, L, L, L, 32'h00, L, L};
        tbl[1]  = '{L, L, L, L, 32'h00, L,  L, L, H, L, 32'h00, L, H};
        tbl[2]  = '{L, L, L, L, 32'h00, L,  L, L, L, L, 32'h00, L, H};
        tbl[3]  = '{L, L, L, H, 32'h30, L,  L, L, L, L, 32'h00, L, H};
        tbl[4]  = '{L, L, L, L, 32'h00, H,  L, L, L, H, 32'h30, L, H};
        tbl[5]  = '{H, H, L, L, 32'h00, L,  L, H, L, L, 32'h00, L, L};
        tbl[6]  = '{H, H, L, H, 32'h99, L,  L, L, H, L, 32'h00, L, H};
        tbl[7]  = '{H, H, L, H, 32'h15, L,  L, L, L, L, 32'h00, L, H};
        tbl[8]  = '{H, H, L, L, 32'h00, H,  L, L, L, H, 32'h15, H, H};
        tbl[9]  = '{H, H, L, L, 32'h00, L,  H, L, L, L, 32'h00, L, L};
        tbl[10] = '{H, H, L, L, 32'h00, L,  L, L, H, L, 32'h00, L, H};
        tbl[11] = '{H, H, L, H, 32'h30, L,  L, L, L, L, 32'h00, L, H};
        tbl[12] = '{H, H, L, L, 32'h00, H,  L, L, L, H, 32'h30, L, H};
        tbl[13] = '{H, H, L, L, 32'h00, L,  L, H, L, L, 32'h00, L, L};
        tbl[14] = '{L, L, L, L, 32'h00, L,  L, L, H, L, 32'h00, L, H};
        tbl[15] = '{L, L, L, H, 32'h15, L,  L, L, L, L, 32'h00, L, H};
        tbl[16] = '{L, L, L, L, 32'h00, H,  L, L, L, H, 32'h15, H, H};
        tbl[17] = '{L, L, L, L, 32'h00, L,  L, L, L, L, 32'h00, L, L};

        // Reset state
        tick(); tick();
        rst_i = 1'b0;
        #1;
        chk1("rst_start", dp_start_o, L);
        chk1("rst_abort", dp_abort_o, L);
        chk1("rst_res_valid", res_valid_o, L);
        chk1("rst_busy", busy_o, L);
        chk32("rst_op_a", dp_op_a_o, 32'h0);
        chk32("rst_result", res_result_o, 32'h0);
        chk1("rst_timeout", res_timeout_o, L);
        chk1("rst_ready0", req0_ready_o, L);

        // Single op then alternating contention
        for (int i = 0; i < 18; i++) begin
            req0_valid_i = tbl[i].v0;
            req1_valid_i = tbl[i].v1;
            flush_i      = tbl[i].fl;
            dp_done_i    = tbl[i].dn;
            dp_result_i  = tbl[i].res;
            res_ready_i  = tbl[i].rr;
            #1;
            chk1($sformatf("tbl%0d_ready0", i), req0_ready_o, tbl[i].e_r0);
            chk1($sformatf("tbl%0d_ready1", i), req1_ready_o, tbl[i].e_r1);
            chk1($sformatf("tbl%0d_start", i), dp_start_o, tbl[i].e_st);
            chk1($sformatf("tbl%0d_abort", i), dp_abort_o, L);
            chk1($sformatf("tbl%0d_res_valid", i), res_valid_o, tbl[i].e_rv);
            chk1($sformatf("tbl%0d_busy", i), busy_o, tbl[i].e_busy);
            if (tbl[i].e_rv) begin
                chk32($sformatf("tbl%0d_result", i), res_result_o, tbl[i].e_res);
                chk1($sformatf("tbl%0d_src", i), res_src_o, tbl[i].e_src);
                chk32($sformatf("tbl%0d_tag", i), 32'(res_trans_id_o), tbl[i].e_src ? 32'd2 : 32'd5);
                chk1($sformatf("tbl%0d_tmo", i), res_timeout_o, L);
            end
            tick();
        end
        req0_valid_i = 1'b0; req1_valid_i = 1'b0; dp_done_i = 1'b0; res_ready_i = 1'b0;

        // Backpressure: result held for 5 cycles, no grant, late done ignored
        start_op(1'b0);
        #1;
        chk32("bp_op_a", dp_op_a_o, 32'h10);
        chk32("bp_op_b", dp_op_b_o, 32'h20);
        tick();
        dp_done_i = 1'b1; dp_result_i = 32'h77;
        tick();
        dp_result_i = 32'h99;
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk1("bp_res_valid", res_valid_o, H);
            chk32("bp_result", res_result_o, 32'h77);
            chk32("bp_tag", 32'(res_trans_id_o), 32'd5);
            chk1("bp_src", res_src_o, L);
            chk1("bp_no_grant", req0_ready_o | req1_ready_o, L);
            chk1("bp_busy", busy_o, H);
            tick();
        end
        dp_done_i = 1'b0; req0_valid_i = 1'b0; req1_valid_i = 1'b0; res_ready_i = 1'b1;
        #1;
        chk1("bp_res_valid_last", res_valid_o, H);
        tick();
        res_ready_i = 1'b0;
        #1;
        chk1("bp_after_valid", res_valid_o, L);
        chk1("bp_after_busy", busy_o, L);

        // Timeout with no done
        start_op(1'b1);
        #1;
        chk1("tmo_start", dp_start_o, H);
        chk32("tmo_op_a", dp_op_a_o, 32'hA);
        tick();
        abort_seen = 0;
        for (int k = 1; k < TMO; k++) begin
            #1;
            if (dp_abort_o) abort_seen++;
            tick();
        end
        chk32("tmo_early_abort", 32'(abort_seen), 32'd0);
        #1;
        chk1("tmo_abort", dp_abort_o, H);
        chk1("tmo_not_yet_valid", res_valid_o, L);
        tick();
        #1;
        chk1("tmo_abort_one_cycle", dp_abort_o, L);
        chk1("tmo_res_valid", res_valid_o, H);
        chk32("tmo_result", res_result_o, 32'h0);
        chk1("tmo_flag", res_timeout_o, H);
        chk1("tmo_src", res_src_o, H);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;
        #1;
        chk1("tmo_valid_fall", res_valid_o, L);
        chk1("tmo_flag_clear", res_timeout_o, L);

        // Done coincides with the expiry cycle: done wins, no abort
        start_op(1'b0);
        tick();
        for (int k = 1; k < TMO; k++) tick();
        dp_done_i = 1'b1; dp_result_i = 32'h55;
        #1;
        chk1("tmo_done_no_abort", dp_abort_o, L);
        tick();
        dp_done_i = 1'b0;
        #1;
        chk1("tmo_done_valid", res_valid_o, H);
        chk32("tmo_done_result", res_result_o, 32'h55);
        chk1("tmo_done_flag", res_timeout_o, L);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;

        // Flush in RUN, done 3 cycles later is discarded, then a new request is accepted
        start_op(1'b0);
        tick();
        flush_i = 1'b1;
        #1;
        chk1("flrun_no_abort", dp_abort_o, L);
        tick();
        flush_i = 1'b0;
        req0_valid_i = 1'b1;
        for (int k = 0; k < 2; k++) begin
            #1;
            chk1("flrun_busy", busy_o, H);
            chk1("flrun_no_valid", res_valid_o, L);
            chk1("flrun_no_grant", req0_ready_o, L);
            tick();
        end
        dp_done_i = 1'b1; dp_result_i = 32'hEE;
        #1;
        chk1("flrun_done_no_abort", dp_abort_o, L);
        tick();
        dp_done_i = 1'b0;
        #1;
        chk1("flrun_idle", busy_o, L);
        chk1("flrun_dropped", res_valid_o, L);
        chk1("flrun_next_ready", req0_ready_o, H);
        tick();
        req0_valid_i = 1'b0;
        #1;
        chk1("flrun_next_start", dp_start_o, H);
        tick();
        dp_done_i = 1'b1; dp_result_i = 32'h30;
        tick();
        dp_done_i = 1'b0;
        #1;
        chk1("flrun_next_valid", res_valid_o, H);
        chk32("flrun_next_result", res_result_o, 32'h30);
        res_ready_i = 1'b1;
        tick();
        res_ready_i = 1'b0;

        // Flush in IDLE blocks acceptance
        req0_valid_i = 1'b1; flush_i = 1'b1;
        #1;
        chk1("flidle_ready", req0_ready_o, L);
        tick();
        req0_valid_i = 1'b0; flush_i = 1'b0;
        #1;
        chk1("flidle_busy", busy_o, L);

        // Flush in RESP drops the result
        start_op(1'b1);
        tick();
        dp_done_i = 1'b1; dp_result_i = 32'h42;
        tick();
        dp_done_i = 1'b0;
        #1;
        chk1("flresp_valid", res_valid_o, H);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        #1;
        chk1("flresp_dropped", res_valid_o, L);
        chk1("flresp_idle", busy_o, L);

        // Reset mid-RUN
        start_op(1'b0);
        tick();
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk1("rstrun_start", dp_start_o, L);
        chk1("rstrun_busy", busy_o, L);
        chk1("rstrun_valid", res_valid_o, L);
        chk1("rstrun_abort", dp_abort_o, L);
        chk32("rstrun_op_a", dp_op_a_o, 32'h0);
        dp_done_i = 1'b1; dp_result_i = 32'h123;
        tick();
        dp_done_i = 1'b0;
        #1;
        chk1("rstrun_late_done_valid", res_valid_o, L);
        chk1("rstrun_late_done_busy", busy_o, L);
        req0_valid_i = 1'b1; req1_valid_i = 1'b1;
        #1;
        chk1("rstrun_pref_ready0", req0_ready_o, H);
        chk1("rstrun_pref_ready1", req1_ready_o, L);
        req0_valid_i = 1'b0; req1_valid_i = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
